mem_arb: RTL and testbench
==========================

Name: mem_arb

Overview:
- Arbiter for the single-port 32-bit word memory (16-bit address) shared by the edge-detection accelerator and other masters, e.g. an image loader or a result reader.
- Up to N_REQ requesters compete for the memory.
- Grants are round-robin, with burst ownership and forced rotation after MAX_BURST cycles.
- Sits between the requesters' addr/dataW/en/we buses and the memory.

Parameters:
- N_REQ, 2, number of requesters (2..4).
- MAX_BURST, 16, cycles an owner may hold the memory while another requester is waiting.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- req_en  in  N_REQ  per-requester request; held high for as long as the requester wants the memory.
- req_we  in  N_REQ  per-requester write strobe.
- req_addr  in  N_REQ*16  packed addresses, requester i at [16i+15:16i].
- req_dataW  in  N_REQ*32  packed write data.
- gnt  out  N_REQ  one-hot grant.
- rvalid  out  N_REQ  read data valid, per requester.
- rdata  out  32  read data, broadcast to all requesters.
- mem_addr  out  16  memory address.
- mem_dataW  out  32  memory write data.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_dataR  in  32  memory read data, valid one cycle after a read.

Behaviour:
- Reset (reset low, asynchronous) sets:
  - state IDLE, owner 0, last_owner N_REQ-1, burst_cnt 0;
  - gnt 0, rvalid 0, mem_en 0, mem_we 0, mem_addr 0, mem_dataW 0.
- States: IDLE, OWN.
- IDLE:
  - mem_* driven 0.
  - If any req_en is high, the winner is the first requester with req_en high, searching from last_owner+1 modulo N_REQ.
  - On the next clock: owner <= winner, state <= OWN, burst_cnt <= 0.
  - Arbitration latency is one cycle.
- OWN:
  - gnt[owner] = 1; all other gnt bits are 0.
  - mem_addr, mem_dataW and mem_we are combinational muxes of the owner's inputs.
  - mem_en = req_en[owner].
  - burst_cnt increments each cycle, saturating at MAX_BURST-1.
- Release: req_en[owner] low in OWN.
  - No transaction occurs that cycle.
  - If another requester is pending, hand off directly: owner <= next RR candidate, burst_cnt <= 0, state stays OWN, no idle bubble.
  - Otherwise state <= IDLE.
  - In both cases last_owner <= owner.
- Preemption: when burst_cnt == MAX_BURST-1, req_en[owner] is high, and any other req_en is high:
  - the current cycle's transaction completes;
  - the next cycle hands off to the next RR candidate;
  - last_owner <= owner.
  - The preempted requester keeps req_en high and re-enters arbitration.
  - Requesters must hold their request while gnt is low.
- Sole requester: never preempted; burst_cnt saturates.
- Read return:
  - A granted cycle with mem_en=1 and mem_we=0 sets rvalid[owner] one cycle later, with rdata = mem_dataR.
  - rvalid is tagged to the owner at issue time, so it stays correct across a handoff.
  - rvalid is high for one cycle per read.
- Writes: take effect in the granted cycle; no response.
- Simultaneous requests from IDLE: the RR order decides.
  - After reset, requester 0 wins a simultaneous request.
- Reset mid-burst: all state clears immediately; any outstanding rvalid is dropped.

Optional Feature:
- ARB_FIXED_PRIO_EN defined:
  - The winner is the lowest-index pending requester.
  - Requester 0 is never preempted; MAX_BURST applies only to owners other than 0.
  - Requester 0 requesting while another owner holds the memory forces a handoff after the current cycle.
- Not defined: round-robin as above.

Decomposition:
- Package arb_pkg holds:
  - state_t enum {IDLE, OWN};
  - ADDR_W=16, DATA_W=32;
  - function rr_next(last, req) returning the next pending index.
- One sub-module, arb_rr_pick: combinational round-robin/priority picker, reused for the IDLE and handoff decisions.

Test Plan:
- Single requester: req0 reads addr 0x0010 for 3 cycles.
  - gnt[0] rises 1 cycle after req_en.
  - mem_addr=0x0010 while granted.
  - rvalid[0] high 1 cycle after each read, rdata = mem_dataR.
- Simultaneous request right after reset: req0 and req1 rise together.
  - gnt[0] first.
  - When req0 drops after 4 cycles, gnt[1] is high on the next cycle, with no IDLE cycle.
- Preemption, MAX_BURST=16: req0 is continuous and req1 rises at req0's burst cycle 5.
  - req0 keeps the grant through burst cycle 15, then gnt[1].
  - req1 continuous: after 16 of its own cycles, gnt returns to req0.
- Write path: req1 granted, we=1, addr 0x6300, dataW 0xDEADBEEF.
  - mem_we=1, mem_addr=0x6300, mem_dataW=0xDEADBEEF for exactly the granted cycles.
  - No rvalid.
- Handoff read tag: req0's last read is issued in the cycle before handoff to req1.
  - rvalid[0] (not rvalid[1]) is asserted in the first cycle of req1's ownership.
- Reset mid-burst: reset low during an OWN read.
  - gnt, mem_en and rvalid are 0 immediately.
  - After release, req1 alone is granted after 1 cycle.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the memory arbiter: FSM states, bus widths and
// the round-robin search used by the picker.
package arb_pkg;

  typedef enum logic {IDLE, OWN} state_t;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  // First pending index after 'last', wrapping modulo n; returns 'last' when
  // nothing is pending (callers qualify with |req).
  function automatic logic [1:0] rr_next(input logic [1:0] last,
                                         input logic [3:0] req,
                                         input int         n);
    logic [1:0] pick;
    logic [1:0] idx;
    logic       found;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = 2'((int'(last) + i) % n);
      if (i <= n && !found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational winner picker shared by the IDLE and handoff decisions.
// With ARB_FIXED_PRIO_EN the lowest pending index wins instead of round-robin.
module arb_rr_pick
  import arb_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [1:0]       base,
  input  logic [N_REQ-1:0] req,
  output logic             valid,
  output logic [1:0]       idx
);

  logic [3:0] req_pad;

  always_comb begin
    req_pad              = '0;
    req_pad[N_REQ-1:0]   = req;
  end

  assign valid = |req;

`ifdef ARB_FIXED_PRIO_EN
  logic unused_base;
  assign unused_base = ^base;
  // Searching from the top index wraps to 0 first, giving lowest-index priority.
  assign idx = rr_next(2'(N_REQ - 1), req_pad, N_REQ);
`else
  assign idx = rr_next(base, req_pad, N_REQ);
`endif

endmodule

// File: rtl/mem_arb.sv
// mem_arb: arbiter for the shared single-port word memory with burst ownership
// and forced rotation after MAX_BURST cycles. ARB_FIXED_PRIO_EN selects fixed priority.
module mem_arb
  import arb_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int MAX_BURST = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_en,
  input  logic [N_REQ-1:0]          req_we,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_dataW,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_dataW,
  output logic                      mem_en,
  output logic                      mem_we,
  input  logic [DATA_W-1:0]         mem_dataR
);

  localparam int CW = $clog2(MAX_BURST + 1);

  state_t           state;
  logic [1:0]       owner;
  logic [1:0]       last_owner;
  logic [CW-1:0]    burst_cnt;
  logic [N_REQ-1:0] rvalid_q;

  logic [N_REQ-1:0]  owner_oh;
  logic [N_REQ-1:0]  others;
  logic              owner_en;
  logic              owner_we;
  logic [ADDR_W-1:0] owner_addr;
  logic [DATA_W-1:0] owner_dataW;
  logic              cnt_max;
  logic              preempt;
  logic              pick_valid;
  logic [1:0]        pick_base;
  logic [1:0]        pick_idx;
  logic [N_REQ-1:0]  pick_req;

  always_comb begin
    owner_oh    = '0;
    owner_en    = 1'b0;
    owner_we    = 1'b0;
    owner_addr  = '0;
    owner_dataW = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner == 2'(i)) begin
        owner_oh[i] = 1'b1;
        owner_en    = req_en[i];
        owner_we    = req_we[i];
        owner_addr  = req_addr[i*ADDR_W +: ADDR_W];
        owner_dataW = req_dataW[i*DATA_W +: DATA_W];
      end
    end
  end

  assign others  = req_en & ~owner_oh;
  assign cnt_max = (burst_cnt == CW'(MAX_BURST - 1));

`ifdef ARB_FIXED_PRIO_EN
  // Requester 0 is never rotated out, and its request evicts any other owner.
  assign preempt = owner_en && (owner != 2'd0) && (|others) && (cnt_max || req_en[0]);
`else
  assign preempt = owner_en && (|others) && cnt_max;
`endif

  // The current owner is masked out so a handoff always moves to someone else.
  assign pick_base = (state == IDLE) ? last_owner : owner;
  assign pick_req  = (state == IDLE) ? req_en : others;

  arb_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .base  (pick_base),
    .req   (pick_req),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= 2'd0;
      last_owner <= 2'(N_REQ - 1);
      burst_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner     <= pick_idx;
            state     <= OWN;
            burst_cnt <= '0;
          end
        end
        OWN: begin
          if (!owner_en) begin
            last_owner <= owner;
            if (pick_valid) begin
              owner     <= pick_idx;
              burst_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end else if (preempt) begin
            last_owner <= owner;
            owner      <= pick_idx;
            burst_cnt  <= '0;
          end else if (!cnt_max) begin
            burst_cnt <= burst_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read responses are tagged with the owner at issue time, surviving a handoff.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid_q <= '0;
    end else if (state == OWN && owner_en && !owner_we) begin
      rvalid_q <= owner_oh;
    end else begin
      rvalid_q <= '0;
    end
  end

  assign gnt       = (state == OWN) ? owner_oh : '0;
  assign mem_en    = (state == OWN) && owner_en;
  assign mem_we    = (state == OWN) && owner_we;
  assign mem_addr  = (state == OWN) ? owner_addr : '0;
  assign mem_dataW = (state == OWN) ? owner_dataW : '0;
  assign rvalid    = rvalid_q;
  assign rdata     = mem_dataR;

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed scenarios plus randomized traffic
// compared against a cycle-level ownership model with a shadow memory.
module tb_mem_arb;

  localparam int N  = 3;
  localparam int MB = 16;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req_en, req_we, gnt, rvalid;
  logic [N*16-1:0] req_addr;
  logic [N*32-1:0] req_dataW;
  logic [31:0]     rdata, mem_dataW, mem_dataR;
  logic [15:0]     mem_addr;
  logic            mem_en, mem_we;
  logic            mem_load;
  logic [31:0]     mem [256];
  int              total, bad;

  mem_arb #(.N_REQ(N), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .req_en(req_en), .req_we(req_we),
    .req_addr(req_addr), .req_dataW(req_dataW), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_dataW(mem_dataW),
    .mem_en(mem_en), .mem_we(mem_we), .mem_dataR(mem_dataR)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_init(int k);
    return 32'h1000_0000 + 32'(k) * 32'h0001_0003;
  endfunction

  // Memory model with one-cycle read latency, as seen by the arbiter.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int k = 0; k < 256; k++) mem[k] <= mem_init(k);
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_dataW;
      else mem_dataR <= mem[mem_addr[7:0]];
    end
  end

  function automatic int first_after(int from, int excl, logic [N-1:0] en);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (from + k) % N;
      if (c != excl && en[c]) return c;
    end
    return -1;
  endfunction

  task automatic set_req(int i, logic en, logic we, logic [15:0] a, logic [31:0] d);
    req_en[i]            = en;
    req_we[i]            = we;
    req_addr[i*16 +: 16] = a;
    req_dataW[i*32 +: 32] = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    req_en    = '0;
    req_we    = '0;
    req_addr  = '0;
    req_dataW = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 16'h0100 + 16'(i), 32'hA0 + 32'(i));
    next_cycle();
    next_cycle();
    #2 reset = 1'b0;
    #1;
    total++; if (gnt !== '0) begin bad++; $display("[TB] FAIL reset_gnt: got %b expected 000", gnt); end
    total++; if (rvalid !== '0) begin bad++; $display("[TB] FAIL reset_rvalid: got %b expected 000", rvalid); end
    total++; if (mem_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_en: got %b expected 0", mem_en); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_we: got %b expected 0", mem_we); end
    total++; if (mem_addr !== 16'h0) begin bad++; $display("[TB] FAIL reset_mem_addr: got %h expected 0000", mem_addr); end
    total++; if (mem_dataW !== 32'h0) begin bad++; $display("[TB] FAIL reset_mem_dataW: got %h expected 0", mem_dataW); end
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    total++; if (gnt !== 3'b000) begin bad++; $display("[TB] FAIL reset_latency: got %b expected 000", gnt); end
    next_cycle();
    @(negedge clk);
    total++; if (gnt !== 3'b001) begin bad++; $display("[TB] FAIL reset_first_winner: got %b expected 001", gnt); end
  endtask

  task automatic test_single_read();
    logic [2:0] exp_rv;
    do_reset();
    set_req(0, 1'b1, 1'b0, 16'h0010, 32'h0);
    @(negedge clk);
    total++; if (gnt !== 3'b000) begin bad++; $display("[TB] FAIL single_latency: got %b expected 000", gnt); end
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      @(negedge clk);
      total++;
      if (gnt !== 3'b001 || mem_addr !== 16'h0010 || mem_en !== 1'b1 || mem_we !== 1'b0) begin
        bad++; $display("[TB] FAIL single_grant c%0d: got gnt=%b addr=%h en=%b we=%b expected 001/0010/1/0", c, gnt, mem_addr, mem_en, mem_we);
      end
      exp_rv = (c >= 2) ? 3'b001 : 3'b000;
      total++; if (rvalid !== exp_rv) begin bad++; $display("[TB] FAIL single_rvalid c%0d: got %b expected %b", c, rvalid, exp_rv); end
      if (c >= 2) begin
        total++; if (rdata !== mem_init(16)) begin bad++; $display("[TB] FAIL single_rdata c%0d: got %h expected %h", c, rdata, mem_init(16)); end
      end
    end
    next_cycle();
    set_req(0, 1'b0, 1'b0, 16'h0, 32'h0);
    @(negedge clk);
    total++;
    if (mem_en !== 1'b0 || rvalid !== 3'b001 || rdata !== mem_init(16)) begin
      bad++; $display("[TB] FAIL single_release: got en=%b rvalid=%b rdata=%h expected 0/001/%h", mem_en, rvalid, rdata, mem_init(16));
    end
    next_cycle();
    @(negedge clk);
    total++; if (gnt !== 3'b000 || rvalid !== 3'b000) begin bad++; $display("[TB] FAIL single_idle: got gnt=%b rvalid=%b expected 000/000", gnt, rvalid); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    set_req(0, 1'b1, 1'b0, 16'h0001, 32'h0);
    set_req(1, 1'b1, 1'b0, 16'h0002, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      @(negedge clk);
      total++; if (gnt !== 3'b001) begin bad++; $display("[TB] FAIL simul_first c%0d: got %b expected 001", c, gnt); end
    end
    next_cycle();
    set_req(0, 1'b0, 1'b0, 16'h0, 32'h0);
    @(negedge clk);
    total++; if (gnt !== 3'b001 || mem_en !== 1'b0) begin bad++; $display("[TB] FAIL simul_release: got gnt=%b en=%b expected 001/0", gnt, mem_en); end
    next_cycle();
    @(negedge clk);
    total++; if (gnt !== 3'b010 || mem_addr !== 16'h0002) begin bad++; $display("[TB] FAIL simul_handoff: got gnt=%b addr=%h expected 010/0002", gnt, mem_addr); end
  endtask

  task automatic test_preempt();
    do_reset();
    set_req(0, 1'b1, 1'b0, 16'h0005, 32'h0);
    for (int c = 1; c <= 16; c++) begin
      next_cycle();
      if (c == 6) set_req(1, 1'b1, 1'b0, 16'h0006, 32'h0);
      @(negedge clk);
      total++; if (gnt !== 3'b001) begin bad++; $display("[TB] FAIL preempt_hold0 burst%0d: got %b expected 001", c - 1, gnt); end
    end
    for (int c = 1; c <= 16; c++) begin
      next_cycle();
      @(negedge clk);
      total++; if (gnt !== 3'b010) begin bad++; $display("[TB] FAIL preempt_hold1 burst%0d: got %b expected 010", c - 1, gnt); end
    end
    next_cycle();
    @(negedge clk);
    total++; if (gnt !== 3'b001) begin bad++; $display("[TB] FAIL preempt_return: got %b expected 001", gnt); end
  endtask

  task automatic test_write();
    do_reset();
    set_req(1, 1'b1, 1'b1, 16'h6300, 32'hDEADBEEF);
    @(negedge clk);
    total++; if (mem_we !== 1'b0 || mem_en !== 1'b0) begin bad++; $display("[TB] FAIL write_idle: got we=%b en=%b expected 0/0", mem_we, mem_en); end
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      @(negedge clk);
      total++;
      if (gnt !== 3'b010 || mem_we !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 16'h6300 || mem_dataW !== 32'hDEADBEEF) begin
        bad++; $display("[TB] FAIL write_bus c%0d: got gnt=%b we=%b en=%b addr=%h data=%h expected 010/1/1/6300/deadbeef", c, gnt, mem_we, mem_en, mem_addr, mem_dataW);
      end
      total++; if (rvalid !== 3'b000) begin bad++; $display("[TB] FAIL write_rvalid c%0d: got %b expected 000", c, rvalid); end
    end
    next_cycle();
    set_req(1, 1'b0, 1'b0, 16'h0, 32'h0);
    @(negedge clk);
    total++; if (mem_we !== 1'b0 || mem_en !== 1'b0 || rvalid !== 3'b000) begin bad++; $display("[TB] FAIL write_release: got we=%b en=%b rvalid=%b expected 0/0/000", mem_we, mem_en, rvalid); end
    next_cycle();
    @(negedge clk);
    total++; if (rvalid !== 3'b000 || gnt !== 3'b000) begin bad++; $display("[TB] FAIL write_after: got rvalid=%b gnt=%b expected 000/000", rvalid, gnt); end
  endtask

  task automatic test_handoff_tag();
    do_reset();
    set_req(0, 1'b1, 1'b0, 16'h0020, 32'h0);
    set_req(1, 1'b1, 1'b0, 16'h0030, 32'h0);
    repeat (16) next_cycle();
    next_cycle();
    @(negedge clk);
    total++;
    if (gnt !== 3'b010 || rvalid !== 3'b001 || rdata !== mem_init(32'h20)) begin
      bad++; $display("[TB] FAIL handoff_tag: got gnt=%b rvalid=%b rdata=%h expected 010/001/%h", gnt, rvalid, rdata, mem_init(32'h20));
    end
    next_cycle();
    @(negedge clk);
    total++;
    if (rvalid !== 3'b010 || rdata !== mem_init(32'h30)) begin
      bad++; $display("[TB] FAIL handoff_next: got rvalid=%b rdata=%h expected 010/%h", rvalid, rdata, mem_init(32'h30));
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    set_req(0, 1'b1, 1'b0, 16'h0040, 32'h0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    total++; if (rvalid !== 3'b001) begin bad++; $display("[TB] FAIL midrst_before: got rvalid=%b expected 001", rvalid); end
    #1 reset = 1'b0;
    #1;
    total++; if (gnt !== 3'b000 || mem_en !== 1'b0 || rvalid !== 3'b000) begin bad++; $display("[TB] FAIL midrst_clear: got gnt=%b en=%b rvalid=%b expected 000/0/000", gnt, mem_en, rvalid); end
    set_req(0, 1'b0, 1'b0, 16'h0, 32'h0);
    set_req(1, 1'b1, 1'b0, 16'h0050, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    total++; if (gnt !== 3'b000) begin bad++; $display("[TB] FAIL midrst_latency: got %b expected 000", gnt); end
    next_cycle();
    @(negedge clk);
    total++; if (gnt !== 3'b010) begin bad++; $display("[TB] FAIL midrst_regrant: got %b expected 010", gnt); end
  endtask

  task automatic test_random();
    int          m_owner, m_last, m_held, m_tag, nxt_tag, o;
    logic [31:0] m_rdata;
    logic [31:0] shadow [256];
    logic [N-1:0] e_gnt, e_rv;
    logic        e_en, e_we;
    logic [15:0] e_addr;
    logic [31:0] e_data;
    for (int k = 0; k < 256; k++) shadow[k] = mem_init(k);
    do_reset();
    m_owner = -1; m_last = N - 1; m_held = 0; m_tag = -1; m_rdata = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      // Waiting requesters hold; the owner may drop or change its access.
      for (int i = 0; i < N; i++) begin
        if (req_en[i] && m_owner != i) begin
        end else if (req_en[i]) begin
          if ($urandom_range(11) == 0) set_req(i, 1'b0, 1'b0, 16'h0, 32'h0);
          else set_req(i, 1'b1, 1'($urandom_range(1)), 16'($urandom) | 16'h0080, $urandom);
        end else if ($urandom_range(3) == 0) begin
          set_req(i, 1'b1, 1'($urandom_range(1)), 16'($urandom) | 16'h0080, $urandom);
        end
      end
      e_gnt = (m_owner >= 0) ? N'(1 << m_owner) : '0;
      e_rv  = (m_tag >= 0) ? N'(1 << m_tag) : '0;
      e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_data = '0;
      if (m_owner >= 0) begin
        e_en   = req_en[m_owner];
        e_we   = req_we[m_owner];
        e_addr = req_addr[m_owner*16 +: 16];
        e_data = req_dataW[m_owner*32 +: 32];
      end
      @(negedge clk);
      total++; if (gnt !== e_gnt) begin bad++; $display("[TB] FAIL rand_gnt cyc%0d: got %b expected %b", cyc, gnt, e_gnt); end
      total++; if ({mem_en, mem_we} !== {e_en, e_we}) begin bad++; $display("[TB] FAIL rand_en_we cyc%0d: got %b%b expected %b%b", cyc, mem_en, mem_we, e_en, e_we); end
      total++; if ({mem_addr, mem_dataW} !== {e_addr, e_data}) begin bad++; $display("[TB] FAIL rand_bus cyc%0d: got %h/%h expected %h/%h", cyc, mem_addr, mem_dataW, e_addr, e_data); end
      total++; if (rvalid !== e_rv) begin bad++; $display("[TB] FAIL rand_rvalid cyc%0d: got %b expected %b", cyc, rvalid, e_rv); end
      if (m_tag >= 0) begin
        total++; if (rdata !== m_rdata) begin bad++; $display("[TB] FAIL rand_rdata cyc%0d: got %h expected %h", cyc, rdata, m_rdata); end
      end
      nxt_tag = -1;
      if (m_owner >= 0 && e_en) begin
        if (e_we) shadow[e_addr[7:0]] = e_data;
        else begin
          nxt_tag = m_owner;
          m_rdata = shadow[e_addr[7:0]];
        end
      end
      m_tag = nxt_tag;
      if (m_owner < 0) begin
        if (req_en != '0) begin
          m_owner = first_after(m_last, -1, req_en);
          m_held  = 0;
        end
      end else if (!e_en) begin
        m_last  = m_owner;
        m_owner = first_after(m_owner, m_owner, req_en);
        m_held  = 0;
      end else begin
        m_held++;
        o = first_after(m_owner, m_owner, req_en);
        if (m_held >= MB && o >= 0) begin
          m_last  = m_owner;
          m_owner = o;
          m_held  = 0;
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b0;
    req_en    = '0;
    req_we    = '0;
    req_addr  = '0;
    req_dataW = '0;
    mem_load  = 1'b1;
    @(posedge clk);
    #1 mem_load = 1'b0;
    test_reset();
    test_single_read();
    test_simultaneous();
    test_preempt();
    test_write();
    test_handoff_tag();
    test_reset_mid_burst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
